// File: rtl/demultiplexor_1a4_tdm_if.sv
// Link-side bundle of the 1-to-4 TDM demultiplexor: one serialized input
// stream in, one rebuilt 4-channel word plus framing status out.
interface demultiplexor_1a4_tdm_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0]   din;
  logic               din_valid;
  logic               frame_sync;
  logic [4*WIDTH-1:0] dout;
  logic               dout_valid;
  logic [1:0]         slot;
  logic               locked;
  logic               sync_err;

  // Source of the serialized stream (and consumer of the rebuilt words).
  modport master (
    output din, din_valid, frame_sync,
    input  dout, dout_valid, slot, locked, sync_err
  );

  // The demultiplexor itself.
  modport slave (
    input  din, din_valid, frame_sync,
    output dout, dout_valid, slot, locked, sync_err
  );
endinterface

// File: rtl/demultiplexor_1a4_tdm.sv
// 1-to-4 TDM demultiplexor. A frame-synchronised 2-bit slot counter steers
// each accepted beat into a shadow lane; the slot-3 beat is merged directly
// with lanes 0..2 into the published word, so only three shadow lanes exist.
// Framing violations pulse sync_err and either resync (early sync) or fall
// back to HUNT (missing sync on slot 0).

// One shadow lane: holds the sample of its slot until the frame completes.
// A write wins over a clear so an early-sync beat can restart slot 0 while
// the rest of the partial frame is dropped.
module demultiplexor_1a4_tdm_lane #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // Lane storage: reset, then write, then clear.
  always_ff @(posedge clk) begin
    if (rst)      q <= '0;
    else if (wr)  q <= d;
    else if (clr) q <= '0;
  end
endmodule

module demultiplexor_1a4_tdm #(
  parameter int WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  demultiplexor_1a4_tdm_if.slave bus
);
  localparam int NUM_LANES = 4;
  localparam int SHD_LANES = NUM_LANES - 1;

  localparam logic [0:0] HUNT   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0] state, state_n;
  logic [1:0] slot_q, slot_n;
  logic [SHD_LANES-1:0] wr;
  logic clr, pub, err;
  logic [SHD_LANES-1:0][WIDTH-1:0] shadow;
  logic [NUM_LANES-1:0][WIDTH-1:0] dout_q;
  logic dv_q, err_q;

  // Shadow lanes for slots 0..2.
  genvar gi;
  generate
    for (gi = 0; gi < SHD_LANES; gi++) begin : g_lane
      demultiplexor_1a4_tdm_lane #(.WIDTH(WIDTH)) u_lane (
        .clk (clk),
        .rst (rst),
        .wr  (wr[gi]),
        .clr (clr),
        .d   (bus.din),
        .q   (shadow[gi])
      );
    end
  endgenerate

  // Beat decode: next state/slot, lane writes, clear, publish and error.
  always_comb begin
    state_n = state;
    slot_n  = slot_q;
    wr      = '0;
    clr     = 1'b0;
    pub     = 1'b0;
    err     = 1'b0;
    if (bus.din_valid) begin
      if (state == HUNT) begin
        if (bus.frame_sync) begin
          wr[0]   = 1'b1;
          clr     = 1'b1;
          slot_n  = 2'd1;
          state_n = LOCKED;
        end
      end else if (bus.frame_sync) begin
        // Slot 0 (normal) or early sync: either way this beat starts a frame.
        wr[0]  = 1'b1;
        slot_n = 2'd1;
        if (slot_q != 2'd0) begin
          err = 1'b1;
          clr = 1'b1;
        end
      end else if (slot_q == 2'd0) begin
        // Missing sync where a frame must start: lose lock.
        err     = 1'b1;
        clr     = 1'b1;
        state_n = HUNT;
        slot_n  = 2'd0;
      end else if (slot_q == 2'd3) begin
        pub    = 1'b1;
        clr    = 1'b1;
        slot_n = 2'd0;
      end else begin
        for (int i = 0; i < SHD_LANES; i++)
          if (slot_q == 2'(i)) wr[i] = 1'b1;
        slot_n = slot_q + 2'd1;
      end
    end
  end

  // Control and output registers; pulses last one cycle by construction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= HUNT;
      slot_q <= 2'd0;
      dout_q <= '0;
      dv_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      slot_q <= slot_n;
      dv_q   <= pub;
      err_q  <= err;
      if (pub) dout_q <= {bus.din, shadow};
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dv_q;
  assign bus.slot       = slot_q;
  assign bus.locked     = (state == LOCKED);
  assign bus.sync_err   = err_q;
endmodule

// File: tb/tb_demultiplexor_1a4_tdm.sv
// Bench for the 1-to-4 TDM demultiplexor: a table of per-cycle vectors plus
// hand-written frame sequences; every published word is checked against a
// queue of expected words filled as frames are driven.
module tb_demultiplexor_1a4_tdm;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_dout;

  always #5 clk = ~clk;

  demultiplexor_1a4_tdm_if #(.WIDTH(1)) ifc ();
  demultiplexor_1a4_tdm #(.WIDTH(1)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));

  typedef struct {
    logic r, v, d, fs;
    logic [1:0] slot;
    logic lk, er, dv;
    logic [3:0] dout;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic v, logic d, logic fs, logic [1:0] slot,
                              logic lk, logic er, logic dv, logic [3:0] dout);
    vec_t t;
    t.r = r; t.v = v; t.d = d; t.fs = fs; t.slot = slot;
    t.lk = lk; t.er = er; t.dv = dv; t.dout = dout;
    return t;
  endfunction

  task automatic chk(string nm, int idx, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0h expected %0h", nm, idx, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic d, logic fs);
    ifc.din_valid  = v;
    ifc.din        = d;
    ifc.frame_sync = fs;
  endtask

  // Scoreboard: every dout_valid pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (ifc.dout_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got dout %0h with no word expected", ifc.dout);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (ifc.dout !== e) begin
          errors++;
          $display("FAIL sb_word: got %0h expected %0h", ifc.dout, e);
        end
      end
    end
  end

  // One frame, slot 0 = w[0], with `gaps` idle cycles between beats.
  task automatic send_word(logic [3:0] w, int gaps, int id);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, w[k], k == 0);
      if (k == 3) exp_q.push_back(w);
      step();
      drive(1'b0, 1'b0, 1'b0);
      if (k < 3) begin
        chk("frm_dv_low", id, 32'(ifc.dout_valid), 0);
        chk("frm_dout_hold", id, 32'(ifc.dout), 32'(exp_dout));
        chk("frm_slot", id, 32'(ifc.slot), k + 1);
        for (int g = 0; g < gaps; g++) begin
          step();
          chk("gap_dv_low", id, 32'(ifc.dout_valid), 0);
          chk("gap_dout_hold", id, 32'(ifc.dout), 32'(exp_dout));
        end
      end else begin
        exp_dout = w;
        chk("frm_dv_high", id, 32'(ifc.dout_valid), 1);
        chk("frm_dout", id, 32'(ifc.dout), 32'(w));
        chk("frm_slot_wrap", id, 32'(ifc.slot), 0);
      end
      chk("frm_no_err", id, 32'(ifc.sync_err), 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);

    //                r  v  d  fs slot lk er dv dout
    tbl.push_back(mk(1, 0, 0, 0, 2'd0, 0, 0, 0, 4'h0)); // reset
    tbl.push_back(mk(0, 1, 1, 1, 2'd1, 1, 0, 0, 4'h0)); // basic frame 0101
    tbl.push_back(mk(0, 1, 0, 0, 2'd2, 1, 0, 0, 4'h0));
    tbl.push_back(mk(0, 1, 1, 0, 2'd3, 1, 0, 0, 4'h0));
    tbl.push_back(mk(0, 1, 0, 0, 2'd0, 1, 0, 1, 4'h5));
    tbl.push_back(mk(0, 0, 0, 0, 2'd0, 1, 0, 0, 4'h5)); // pulse ends, dout holds
    tbl.push_back(mk(0, 1, 1, 1, 2'd1, 1, 0, 0, 4'h5)); // early-sync sequence
    tbl.push_back(mk(0, 1, 1, 0, 2'd2, 1, 0, 0, 4'h5));
    tbl.push_back(mk(0, 1, 0, 1, 2'd1, 1, 1, 0, 4'h5)); // early sync
    tbl.push_back(mk(0, 0, 0, 0, 2'd1, 1, 0, 0, 4'h5)); // sync_err one cycle
    tbl.push_back(mk(0, 1, 1, 0, 2'd2, 1, 0, 0, 4'h5));
    tbl.push_back(mk(0, 1, 1, 0, 2'd3, 1, 0, 0, 4'h5));
    tbl.push_back(mk(0, 1, 0, 0, 2'd0, 1, 0, 1, 4'h6)); // resynced frame 0110
    tbl.push_back(mk(0, 1, 1, 0, 2'd0, 0, 1, 0, 4'h6)); // slot-0 violation
    tbl.push_back(mk(0, 0, 0, 0, 2'd0, 0, 0, 0, 4'h6));
    tbl.push_back(mk(0, 1, 1, 0, 2'd0, 0, 0, 0, 4'h6)); // HUNT discards
    tbl.push_back(mk(0, 1, 0, 0, 2'd0, 0, 0, 0, 4'h6));
    tbl.push_back(mk(0, 1, 1, 0, 2'd0, 0, 0, 0, 4'h6));
    tbl.push_back(mk(0, 1, 1, 1, 2'd1, 1, 0, 0, 4'h6)); // reset mid-frame
    tbl.push_back(mk(0, 1, 0, 0, 2'd2, 1, 0, 0, 4'h6));
    tbl.push_back(mk(0, 1, 1, 0, 2'd3, 1, 0, 0, 4'h6));
    tbl.push_back(mk(1, 0, 0, 0, 2'd0, 0, 0, 0, 4'h0));
    tbl.push_back(mk(0, 1, 0, 0, 2'd0, 0, 0, 0, 4'h0)); // orphan slot-3 beat

    foreach (tbl[i]) begin
      rst = tbl[i].r;
      drive(tbl[i].v, tbl[i].d, tbl[i].fs);
      if (tbl[i].dv) exp_q.push_back(tbl[i].dout);
      step();
      chk("slot", i, 32'(ifc.slot), 32'(tbl[i].slot));
      chk("locked", i, 32'(ifc.locked), 32'(tbl[i].lk));
      chk("sync_err", i, 32'(ifc.sync_err), 32'(tbl[i].er));
      chk("dout_valid", i, 32'(ifc.dout_valid), 32'(tbl[i].dv));
      chk("dout", i, 32'(ifc.dout), 32'(tbl[i].dout));
    end

    // Fresh reset, then a gapped frame and three back-to-back frames.
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    exp_dout = 4'h0;
    chk("rst2_dout", 0, 32'(ifc.dout), 0);
    send_word(4'b0101, 2, 1);
    step();
    chk("gap_pulse_end", 1, 32'(ifc.dout_valid), 0);
    send_word(4'b0101, 0, 2);
    send_word(4'b1111, 0, 3);
    send_word(4'b0011, 0, 4);
    step();
    chk("b2b_pulse_end", 4, 32'(ifc.dout_valid), 0);
    chk("b2b_dout_hold", 4, 32'(ifc.dout), 32'h3);

    // Every expected word must have been consumed by the scoreboard.
    for (int t = 0; t < 4 && exp_q.size() != 0; t++) step();
    chk("sb_drained", 0, 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
